// File: rtl/regbank_pkg.sv
// -----------------------------------------------------------------------------
// regbank_pkg
//   Shared encodings and default sizes for the register-bank write-back slice.
//   RegDst and MemtoReg codes are given names so that the select logic reads
//   like the instruction decode it mirrors. Code 2'b11 of either select is
//   reserved and flags a write-back error.
// -----------------------------------------------------------------------------
package regbank_pkg;

    localparam int unsigned DATA_W_DEFAULT   = 32;
    localparam int unsigned ADDR_W_DEFAULT   = 5;
    localparam int unsigned NREGS_DEFAULT    = 32;
    localparam int unsigned LINK_REG_DEFAULT = 31;

    // Destination register select (RegDst)
    typedef enum logic [1:0] {
        DST_RT   = 2'b00,
        DST_RD   = 2'b01,
        DST_LINK = 2'b10,
        DST_RSVD = 2'b11
    } reg_dst_e;

    // Result source select (MemtoReg)
    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_MEM  = 2'b01,
        SRC_PC4  = 2'b10,
        SRC_RSVD = 2'b11
    } mem_to_reg_e;

endpackage : regbank_pkg

// File: rtl/regbank_writeback_if.sv
// -----------------------------------------------------------------------------
// regbank_writeback_if
//   Bundles the retiring-instruction write-back request, the two operand read
//   ports and the pending-write status of the register bank.
//
//   Signals (direction as seen from the register bank, modport slave):
//     RegWrite   in   request write-back this cycle
//     RegDst     in   dest select   (00 rt, 01 rd, 10 link, 11 reserved)
//     MemtoReg   in   source select (00 ALU, 01 mem, 10 PC+4, 11 reserved)
//     rt, rd     in   register fields of the retiring instruction
//     ALUResult  in   ALU result
//     MemData    in   load data
//     PCplus4    in   return address for link writes
//     ReadReg1/2 in   read port addresses
//     ReadData1/2 out read port data (combinational)
//     wb_valid   out  pending write-back latch holds a write
//     wb_addr    out  pending destination
//     wb_err     out  one-cycle pulse: RegWrite with a reserved select
//   modport master is the mirror image (MEM stage / decode side).
// -----------------------------------------------------------------------------
interface regbank_writeback_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              RegWrite;
    logic [1:0]        RegDst;
    logic [1:0]        MemtoReg;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] ALUResult;
    logic [DATA_W-1:0] MemData;
    logic [DATA_W-1:0] PCplus4;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_err;

    modport master (
        output RegWrite, RegDst, MemtoReg, rt, rd, ALUResult, MemData, PCplus4,
        output ReadReg1, ReadReg2,
        input  ReadData1, ReadData2, wb_valid, wb_addr, wb_err
    );

    modport slave (
        input  RegWrite, RegDst, MemtoReg, rt, rd, ALUResult, MemData, PCplus4,
        input  ReadReg1, ReadReg2,
        output ReadData1, ReadData2, wb_valid, wb_addr, wb_err
    );

endinterface : regbank_writeback_if

// File: rtl/regbank_read_port.sv
// -----------------------------------------------------------------------------
// regbank_read_port
//   One combinational register read port with write-back forwarding.
//   Priority: address 0 reads as zero; otherwise a pending write to the same
//   address supplies its data; otherwise the register array entry is returned.
//
//   Ports:
//     addr_i      in   read address
//     wb_valid_i  in   pending write-back latch holds a write
//     wb_addr_i   in   pending destination
//     wb_data_i   in   pending data
//     regs_i      in   committed register array contents
//     rdata_o     out  read data
// -----------------------------------------------------------------------------
module regbank_read_port #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREGS  = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [DATA_W-1:0] regs_i [NREGS],
    output logic [DATA_W-1:0] rdata_o
);

    always_comb begin
        if (addr_i == '0) begin
            // A captured write to register 0 must never leak through here.
            rdata_o = '0;
        end else if (wb_valid_i && (wb_addr_i == addr_i)) begin
            rdata_o = wb_data_i;
        end else begin
            rdata_o = regs_i[addr_i];
        end
    end

endmodule : regbank_read_port

// File: rtl/regbank_writeback.sv
// -----------------------------------------------------------------------------
// regbank_writeback
//   Write-back end of the register operand path. Each cycle it selects the
//   destination register and result source of the retiring instruction and
//   captures them in a one-deep pending write-back latch; on the following
//   edge the latch is committed into the register bank. Both read ports see
//   the pending write through forwarding, so a result is readable right after
//   the edge that captured it.
//
//   Ports:
//     clock  in   rising-edge clock
//     reset  in   asynchronous, active-high reset (clears bank and latch)
//     bus    slave side of regbank_writeback_if (request, read ports, status)
// -----------------------------------------------------------------------------
module regbank_writeback
    import regbank_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
    parameter int unsigned NREGS    = NREGS_DEFAULT,
    parameter int unsigned LINK_REG = LINK_REG_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    regbank_writeback_if.slave  bus
);

    // Pending write-back latch
    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
    logic [DATA_W-1:0] wb_data_q,  wb_data_d;
    logic              wb_err_q,   wb_err_d;

    // Committed register bank
    logic [DATA_W-1:0] regs_q [NREGS];

    // Source / destination selection
    logic [ADDR_W-1:0] dest_sel;
    logic [DATA_W-1:0] src_sel;
    logic              dest_legal;
    logic              src_legal;
    logic              capture;

    // NOTE: every signal assigned in this always_comb gets a default first, so
    // no path through the case statements can leave one unassigned and infer
    // a latch.
    always_comb begin
        dest_sel   = '0;
        dest_legal = 1'b1;
        src_sel    = '0;
        src_legal  = 1'b1;

        case (reg_dst_e'(bus.RegDst))
            DST_RT:   dest_sel = bus.rt;
            DST_RD:   dest_sel = bus.rd;
            DST_LINK: dest_sel = ADDR_W'(LINK_REG);
            default:  dest_legal = 1'b0;
        endcase

        case (mem_to_reg_e'(bus.MemtoReg))
            SRC_ALU: src_sel = bus.ALUResult;
            SRC_MEM: src_sel = bus.MemData;
            SRC_PC4: src_sel = bus.PCplus4;
            default: src_legal = 1'b0;
        endcase
    end

    assign capture = bus.RegWrite & dest_legal & src_legal;

    // Address/data hold when nothing is captured; only wb_valid qualifies them.
    always_comb begin
        wb_valid_d = capture;
        wb_addr_d  = capture ? dest_sel : wb_addr_q;
        wb_data_d  = capture ? src_sel  : wb_data_q;
        wb_err_d   = bus.RegWrite & ~(dest_legal & src_legal);
    end

    // NOTE: state is updated with non-blocking assignments so that commit
    // below sees the latch contents from before the edge while capture loads
    // the new request on that same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_err_q   <= wb_err_d;
        end
    end

    // NOTE: the bank is reset, which makes it flip-flops rather than a RAM
    // macro; reads must return zero straight out of reset, so this is wanted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_valid_q && (wb_addr_q != '0)) begin
            regs_q[wb_addr_q] <= wb_data_q;
        end
    end

    regbank_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_read_port1 (
        .addr_i     (bus.ReadReg1),
        .wb_valid_i (wb_valid_q),
        .wb_addr_i  (wb_addr_q),
        .wb_data_i  (wb_data_q),
        .regs_i     (regs_q),
        .rdata_o    (bus.ReadData1)
    );

    regbank_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_read_port2 (
        .addr_i     (bus.ReadReg2),
        .wb_valid_i (wb_valid_q),
        .wb_addr_i  (wb_addr_q),
        .wb_data_i  (wb_data_q),
        .regs_i     (regs_q),
        .rdata_o    (bus.ReadData2)
    );

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_err   = wb_err_q;

endmodule : regbank_writeback

// File: tb/tb_regbank_writeback.sv
// -----------------------------------------------------------------------------
// tb_regbank_writeback
//   Self-checking bench for regbank_writeback. A model of the architecturally
//   visible register values is updated at each capturing edge; expected read
//   data and status are queued when a read is set up and popped against the
//   DUT outputs once they have settled.
// -----------------------------------------------------------------------------
module tb_regbank_writeback;
    import regbank_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    regbank_writeback_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regbank_writeback dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [32];
    logic        exp_valid;
    logic        exp_err;
    logic [4:0]  exp_addr;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic compare_next(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", got, 32'hxxxx_xxxx);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_addr  = '0;
    endtask

    task automatic drive_wb(input logic we, input logic [1:0] dst, input logic [1:0] src,
                            input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [31:0] mem,
                            input logic [31:0] pc4);
        bus.RegWrite  = we;
        bus.RegDst    = dst;
        bus.MemtoReg  = src;
        bus.rt        = rt;
        bus.rd        = rd;
        bus.ALUResult = alu;
        bus.MemData   = mem;
        bus.PCplus4   = pc4;
    endtask

    task automatic drive_idle();
        drive_wb(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    // Advance one edge and update the model from the request held across it.
    task automatic tick();
        logic        legal;
        logic [4:0]  dest;
        logic [31:0] data;
        @(posedge clock);
        #1;
        legal = (bus.RegDst != 2'b11) && (bus.MemtoReg != 2'b11);
        case (bus.RegDst)
            2'b00:   dest = bus.rt;
            2'b01:   dest = bus.rd;
            default: dest = 5'd31;
        endcase
        case (bus.MemtoReg)
            2'b00:   data = bus.ALUResult;
            2'b01:   data = bus.MemData;
            default: data = bus.PCplus4;
        endcase
        exp_valid = bus.RegWrite && legal;
        exp_err   = bus.RegWrite && !legal;
        if (exp_valid) begin
            exp_addr = dest;
            if (dest != 5'd0) model[dest] = data;
        end
    endtask

    task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        bus.ReadReg1 = a1;
        bus.ReadReg2 = a2;
        exp_q.push_back('{{tag, ".rd1"}, model[a1]});
        exp_q.push_back('{{tag, ".rd2"}, model[a2]});
        exp_q.push_back('{{tag, ".wb_valid"}, {31'b0, exp_valid}});
        exp_q.push_back('{{tag, ".wb_err"}, {31'b0, exp_err}});
        if (exp_valid) exp_q.push_back('{{tag, ".wb_addr"}, {27'b0, exp_addr}});
        #1;
        compare_next(bus.ReadData1);
        compare_next(bus.ReadData2);
        compare_next({31'b0, bus.wb_valid});
        compare_next({31'b0, bus.wb_err});
        if (exp_valid) compare_next({27'b0, bus.wb_addr});
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        drive_idle();
        bus.ReadReg1 = '0;
        bus.ReadReg2 = '0;
        #12;
        read_check("reset", 5'd5, 5'd31);
        reset = 1'b0;

        // Write + forward: visible right after the capture edge, then from array
        drive_wb(1'b1, DST_RD, SRC_ALU, 5'd0, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0);
        tick();
        read_check("fwd", 5'd5, 5'd0);
        drive_idle();
        tick();
        read_check("array", 5'd5, 5'd5);

        // Back-to-back writes to r7
        drive_wb(1'b1, DST_RD, SRC_ALU, 5'd0, 5'd7, 32'h1, 32'h0, 32'h0);
        tick();
        read_check("b2b_1", 5'd5, 5'd7);
        drive_wb(1'b1, DST_RD, SRC_ALU, 5'd0, 5'd7, 32'h2, 32'h0, 32'h0);
        tick();
        read_check("b2b_2", 5'd7, 5'd7);
        drive_idle();
        tick();
        read_check("b2b_3", 5'd5, 5'd7);

        // Link write to r31
        drive_wb(1'b1, DST_LINK, SRC_PC4, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0040_0008);
        tick();
        read_check("link", 5'd31, 5'd3);
        drive_idle();
        tick();
        read_check("link_arr", 5'd4, 5'd31);

        // Register 0 write: captured but never visible
        drive_wb(1'b1, DST_RT, SRC_MEM, 5'd0, 5'd9, 32'h0, 32'hFFFF_FFFF, 32'h0);
        tick();
        read_check("zero", 5'd0, 5'd0);
        drive_idle();
        tick();
        read_check("zero_arr", 5'd0, 5'd9);

        // Reserved selects: error pulse, nothing written
        drive_wb(1'b1, DST_RD, SRC_RSVD, 5'd0, 5'd5, 32'h0000_0123, 32'h0, 32'h0);
        tick();
        read_check("rsvd_src", 5'd5, 5'd7);
        drive_wb(1'b1, DST_RSVD, SRC_ALU, 5'd7, 5'd7, 32'h0000_0456, 32'h0, 32'h0);
        tick();
        read_check("rsvd_dst", 5'd7, 5'd31);
        drive_idle();
        tick();
        read_check("rsvd_end", 5'd5, 5'd7);

        // Reset mid-run while a write is pending: discarded, never committed
        drive_wb(1'b1, DST_RD, SRC_ALU, 5'd0, 5'd9, 32'h0000_1234, 32'h0, 32'h0);
        tick();
        read_check("pre_rst", 5'd9, 5'd5);
        drive_idle();
        reset = 1'b1;
        #1;
        model_reset();
        read_check("mid_rst", 5'd9, 5'd5);
        reset = 1'b0;
        tick();
        read_check("post_rst", 5'd9, 5'd31);

        // Random traffic including reserved selects and register 0
        for (int n = 0; n < 300; n++) begin
            drive_wb(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom),
                     $urandom, $urandom, $urandom);
            tick();
            read_check("rand", 5'($urandom), 5'($urandom));
        end

        drive_idle();
        tick();
        for (int r = 0; r < 32; r += 2) begin
            read_check("final", 5'(r), 5'(r + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_regbank_writeback
